// File: rtl/uart_alu_pkg.sv
// rtl/uart_alu_pkg.sv - state encoding, default widths and ALU opcodes for uart_alu_ctrl
package uart_alu_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_timeout.sv
// rtl/uart_alu_timeout.sv - inter-byte timeout counter, used only when RX_TIMEOUT_EN is defined
module uart_alu_timeout #(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en_i,
  input  logic rx_tick_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter restarts whenever we leave the waiting states, a byte is taken, or it fires.
  always_comb begin
    expire_o = count_en_i && !rx_tick_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d    = cnt_q + 1'b1;
    if (!count_en_i || rx_tick_i || expire_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - UART RX -> ALU -> UART TX sequencer; RX_TIMEOUT_EN adds an inter-byte timeout
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_done_tick,
  input  logic               tx_done_tick,
  input  logic [NB_DATA-1:0] alu_result,
  output logic [NB_DATA-1:0] alu_a,
  output logic [NB_DATA-1:0] alu_b,
  output logic [NB_OP-1:0]   alu_op,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  output logic               busy,
  output logic               overrun
`ifdef RX_TIMEOUT_EN
  ,
  output logic               timeout_tick
`endif
);

  if (NB_DATA < 1 || NB_DATA > 8 || NB_OP < 1 || NB_OP > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_alu_ctrl: parameter out of range");
  end

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         result_ext;
  logic               to_expire;

`ifdef RX_TIMEOUT_EN
  uart_alu_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .count_en_i(state_q == ST_WAIT_B || state_q == ST_WAIT_OP),
    .rx_tick_i (rx_done_tick),
    .expire_o  (to_expire)
  );
  assign timeout_tick = to_expire;
`else
  assign to_expire = 1'b0;
`endif

  always_comb begin
    result_ext                = '0;
    result_ext[NB_DATA-1:0]   = alu_result;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_WAIT_A: begin
        if (rx_done_tick) begin
          a_d     = rx_data[NB_DATA-1:0];
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (rx_done_tick) begin
          b_d     = rx_data[NB_DATA-1:0];
          state_d = ST_WAIT_OP;
        end else if (to_expire) begin
          state_d = ST_WAIT_A;
        end
      end
      ST_WAIT_OP: begin
        if (rx_done_tick) begin
          op_d    = rx_data[NB_OP-1:0];
          state_d = ST_EXEC;
        end else if (to_expire) begin
          state_d = ST_WAIT_A;
        end
      end
      ST_EXEC: begin
        tx_data_d = result_ext;
        state_d   = ST_SEND;
        if (rx_done_tick) overrun_d = 1'b1;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
        if (rx_done_tick) overrun_d = 1'b1;
      end
      ST_WAIT_TX: begin
        if (tx_done_tick) state_d = ST_WAIT_A;
        if (rx_done_tick) overrun_d = 1'b1;
      end
      default: state_d = ST_WAIT_A;
    endcase
    // Registered start pulse: high exactly while the FSM sits in SEND.
    tx_start_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != ST_WAIT_A);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb/tb_uart_alu_ctrl.sv - directed self-checking bench for uart_alu_ctrl (timeout steps under RX_TIMEOUT_EN)
module tb_uart_alu_ctrl;
  import uart_alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       tx_done_tick;
  logic [7:0] alu_result;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, busy, overrun;
`ifdef RX_TIMEOUT_EN
  logic       timeout_tick;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_alu_ctrl #(
    .NB_DATA(8),
    .NB_OP(6),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_done_tick(rx_done_tick),
    .tx_done_tick(tx_done_tick),
    .alu_result  (alu_result),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .busy        (busy),
    .overrun     (overrun)
`ifdef RX_TIMEOUT_EN
    ,
    .timeout_tick(timeout_tick)
`endif
  );

  // External ALU stand-in
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      OP_ADD: alu_result = alu_a + alu_b;
      OP_SUB: alu_result = alu_a - alu_b;
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_SRA: alu_result = $signed(alu_a) >>> alu_b;
      OP_SRL: alu_result = alu_a >> alu_b;
      OP_NOR: alu_result = ~(alu_a | alu_b);
      default: alu_result = 8'h00;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;
    int to_count;
    int to_at;
    reset        = 1'b0;
    rx_data      = 8'h00;
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    step();
    step();
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_b", alu_b, 8'h00);
    chk("rst_alu_op", alu_op, 6'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
`ifdef RX_TIMEOUT_EN
    chk("rst_timeout_tick", timeout_tick, 1'b0);
`endif
    reset = 1'b1;
    step();

    // ADD 5 + 3
    send_byte(8'h05);
    chk("add_alu_a", alu_a, 8'h05);
    chk("add_busy_b", busy, 1'b1);
    send_byte(8'h03);
    chk("add_alu_b", alu_b, 8'h03);
    send_byte(8'h20);
    chk("add_alu_op", alu_op, 6'h20);
    chk("add_exec_no_start", tx_start, 1'b0);
    chk("add_exec_tx_data_old", tx_data, 8'h00);
    step();
    chk("add_tx_data", tx_data, 8'h08);
    chk("add_tx_start", tx_start, 1'b1);
    step();
    chk("add_start_one_cycle", tx_start, 1'b0);
    step();
    step();
    chk("add_busy_wait_tx", busy, 1'b1);
    pulse_tx_done();
    chk("add_idle", busy, 1'b0);

    // SUB wrap 3 - 5
    send_byte(8'h03);
    send_byte(8'h05);
    send_byte(8'h22);
    step();
    chk("sub_tx_data", tx_data, 8'hFE);
    chk("sub_tx_start", tx_start, 1'b1);
    step();
    pulse_tx_done();
    chk("sub_idle", busy, 1'b0);
    chk("sub_operands_held", alu_a, 8'h03);

    // tx_done outside WAIT_TX is ignored
    pulse_tx_done();
    chk("txdone_idle_ignored", busy, 1'b0);
    send_byte(8'h0C);
    pulse_tx_done();
    chk("txdone_waitb_ignored", busy, 1'b1);
    send_byte(8'h06);
    chk("and_alu_b", alu_b, 8'h06);
    send_byte(8'h24);
    step();
    chk("and_tx_data", tx_data, 8'h04);
    step();
    chk("pre_overrun_clear", overrun, 1'b0);

    // Overrun while in WAIT_TX
    send_byte(8'h55);
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_alu_a_kept", alu_a, 8'h0C);
    chk("ovr_still_busy", busy, 1'b1);
    pulse_tx_done();
    chk("ovr_idle", busy, 1'b0);
    send_byte(8'hF0);
    send_byte(8'h0F);
    send_byte(8'h25);
    step();
    chk("or_tx_data", tx_data, 8'hFF);
    chk("ovr_sticky", overrun, 1'b1);
    step();
    pulse_tx_done();

    // Reset mid-command, coincident with an rx tick
    send_byte(8'h11);
    send_byte(8'h22);
    reset        = 1'b0;
    rx_data      = 8'h99;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    reset        = 1'b1;
    chk("mid_rst_alu_a", alu_a, 8'h00);
    chk("mid_rst_alu_b", alu_b, 8'h00);
    chk("mid_rst_alu_op", alu_op, 6'h00);
    chk("mid_rst_tx_data", tx_data, 8'h00);
    chk("mid_rst_overrun", overrun, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      if (tx_start) starts++;
      step();
    end
    chk("mid_rst_no_start", starts, 0);
    chk("mid_rst_still_idle", busy, 1'b0);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h20);
    step();
    chk("post_rst_tx_data", tx_data, 8'h02);
    chk("post_rst_tx_start", tx_start, 1'b1);
    step();

    // Coincident rx and tx done in WAIT_TX (SRA 0x80 >>> 1)
    pulse_tx_done();
    send_byte(8'h80);
    send_byte(8'h01);
    send_byte(8'h03);
    step();
    chk("sra_tx_data", tx_data, 8'hC0);
    step();
    rx_data      = 8'h77;
    rx_done_tick = 1'b1;
    tx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    chk("coinc_idle", busy, 1'b0);
    chk("coinc_overrun", overrun, 1'b1);
    chk("coinc_byte_dropped", alu_a, 8'h80);
    send_byte(8'h33);
    chk("coinc_next_a", alu_a, 8'h33);
    send_byte(8'h02);
    send_byte(8'h02);
    step();
    chk("srl_tx_data", tx_data, 8'h0C);
    step();
    pulse_tx_done();

`ifdef RX_TIMEOUT_EN
    // Inter-byte timeout with TIMEOUT_CYCLES = 20
    send_byte(8'h07);
    to_count = 0;
    to_at    = 0;
    for (int i = 1; i <= 25; i++) begin
      if (timeout_tick) begin
        to_count++;
        to_at = i;
      end
      step();
    end
    chk("to_pulse_count", to_count, 1);
    chk("to_pulse_cycle", to_at, 20);
    chk("to_idle", busy, 1'b0);
    chk("to_a_retained", alu_a, 8'h07);
    send_byte(8'h09);
    chk("to_next_a", alu_a, 8'h09);
    chk("to_next_busy", busy, 1'b1);
`else
    to_count = 0;
    to_at    = 0;
    send_byte(8'h07);
    for (int i = 0; i < 30; i++) step();
    chk("no_to_still_waiting", busy, 1'b1);
    send_byte(8'h09);
    chk("no_to_b_loaded", alu_b, 8'h09);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Sequencer between the UART receiver, the ALU and the UART transmitter.
- Collects three received bytes in a fixed order (operand A, operand B, opcode) and drives them onto the ALU.
- Registers the ALU result and hands it to the transmitter with a one-cycle start pulse.
- Holds off further commands until the transmitter reports completion.

Parameters:
- NB_DATA, 8, ALU operand/result width (1..8). Received bytes use LSBs [NB_DATA-1:0]; the result is zero-extended to 8 bits for TX.
- NB_OP, 6, opcode width. Taken from received byte bits [NB_OP-1:0].
- TIMEOUT_CYCLES, 50000000, inter-byte timeout in clk cycles. Used only with RX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset asserted), sampled on rising clk
- rx_data  in  8  byte from UART receiver; valid when rx_done_tick=1
- rx_done_tick  in  1  one-cycle pulse: new received byte
- tx_done_tick  in  1  one-cycle pulse: transmitter finished its byte
- alu_result  in  NB_DATA  combinational ALU output
- alu_a  out  NB_DATA  registered operand A
- alu_b  out  NB_DATA  registered operand B
- alu_op  out  NB_OP  registered opcode
- tx_data  out  8  registered result byte for the transmitter
- tx_start  out  1  one-cycle pulse: start transmission of tx_data
- busy  out  1  high in any state other than WAIT_A
- overrun  out  1  sticky; set when a byte arrives while it cannot be accepted

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=WAIT_A.
  - alu_a, alu_b, alu_op, tx_data = 0.
  - tx_start=0, overrun=0, busy=0.
  - Reset wins over every other event in the same cycle.
  - A reset mid-operation aborts the command; no tx_start is issued afterwards.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on rx_done_tick, alu_a <= rx_data[NB_DATA-1:0]; next state WAIT_B.
- WAIT_B: on rx_done_tick, alu_b <= rx_data[NB_DATA-1:0]; next state WAIT_OP.
- WAIT_OP: on rx_done_tick, alu_op <= rx_data[NB_OP-1:0]; next state EXEC.
- EXEC: exactly one cycle. Operands are stable at the ALU. tx_data <= zero-extended alu_result at the end of the cycle. Next state SEND.
- SEND: exactly one cycle. tx_start=1 (registered output, high only in this cycle). Next state WAIT_TX.
- WAIT_TX: on tx_done_tick, next state WAIT_A; otherwise stay.
- Latency: if the opcode tick arrives at edge N, then EXEC occupies cycle N+1, tx_data is valid from N+2, and tx_start=1 during N+2.
- Operand/opcode registers hold their values until overwritten by the next command. They are not cleared after a transmit.
- rx_done_tick in EXEC, SEND or WAIT_TX: the byte is discarded and overrun <= 1. overrun clears only on reset.
- tx_done_tick outside WAIT_TX: ignored.
- rx_done_tick and tx_done_tick in the same cycle while in WAIT_TX:
  - Transition to WAIT_A.
  - The RX byte is discarded and overrun is set.
- Bits of rx_data above NB_DATA/NB_OP are ignored.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined:
  - Adds an inter-byte counter, width $clog2(TIMEOUT_CYCLES+1).
  - The counter clears on entry to WAIT_B/WAIT_OP and on every accepted byte, and increments each cycle in WAIT_B and WAIT_OP.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_done_tick in that cycle: state <= WAIT_A, and output timeout_tick (1 bit, extra port) pulses for one cycle.
  - Partially loaded operands are retained, not cleared.
  - An rx_done_tick in the terminal cycle is accepted normally; no timeout.
- Not defined: no counter and no timeout_tick port; WAIT_B/WAIT_OP wait indefinitely.

Decomposition:
- Shared package uart_alu_pkg: state encoding constants (3-bit: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SEND=4, WAIT_TX=5), default NB_DATA/NB_OP, and the ALU opcode constants (ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111).
- One sub-module is natural: uart_alu_timeout, the inter-byte counter. It is instantiated only under RX_TIMEOUT_EN. The FSM stays in the top module.

Test Plan:
- Reset, ALU model = ADD: bytes 0x05, 0x03, 0x20 → alu_a=0x05, alu_b=0x03, alu_op=0x20; tx_data=0x08; tx_start high exactly 1 cycle, 2 cycles after the opcode tick; busy=1 until tx_done_tick.
- SUB wrap: 0x03, 0x05, 0x22 → tx_data=0xFE; after tx_done_tick, state WAIT_A and busy=0.
- Overrun: send byte 0x55 while in WAIT_TX → overrun=1; alu_a unchanged; the next full command still executes correctly and overrun stays 1.
- Reset mid-command: 0x11, 0x22, then reset low 1 cycle → all outputs 0, busy=0; a new command 0x01, 0x01, 0x20 → tx_data=0x02.
- Coincident ticks in WAIT_TX: rx_done_tick=1 and tx_done_tick=1 in the same cycle → WAIT_A, byte dropped, overrun=1.
- RX_TIMEOUT_EN, TIMEOUT_CYCLES=20: send 0x07 then idle 25 cycles → timeout_tick pulses once at cycle 20 after acceptance; the next byte 0x09 loads alu_a=0x09.
